// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard scoreboard: register-file geometry and stall-cause encoding.
package hazard_pkg;

    localparam int unsigned NREGS = 32;
    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        RAW  = 2'b01,
        WAW  = 2'b10,
        BUSY = 2'b11
    } stall_cause_t;

    // One-hot mask selecting a single register of the default-sized file.
    function automatic logic [NREGS-1:0] reg_mask(input logic [REG_W-1:0] idx);
        return NREGS'(1) << idx;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode/writeback/mul-div bundle between the pipeline (master) and the hazard scoreboard (slave).
interface hazard_scoreboard_if #(
    parameter int unsigned NREGS = hazard_pkg::NREGS,
    parameter int unsigned REG_W = hazard_pkg::REG_W
) ();
    import hazard_pkg::*;

    logic             id_valid;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [REG_W-1:0] id_rd;
    logic             id_we;
    logic             id_is_load;
    logic             id_is_muldiv;
    logic             flush;
    logic             wb_valid;
    logic [REG_W-1:0] wb_rd;
    logic             md_done;
    logic             stall;
    stall_cause_t     stall_cause;
    logic [NREGS-1:0] pending;
    logic             md_busy;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_we,
        output id_is_load, id_is_muldiv, flush, wb_valid, wb_rd, md_done,
        input  stall, stall_cause, pending, md_busy
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_we,
        input  id_is_load, id_is_muldiv, flush, wb_valid, wb_rd, md_done,
        output stall, stall_cause, pending, md_busy
    );

endinterface

// File: rtl/pending_bitmap.sv
// Per-index pending bit vector with one set port and one clear port; set wins on a collision.
module pending_bitmap #(
    parameter int unsigned N = 32,
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         set_en,
    input  logic [W-1:0] set_idx,
    input  logic         clr_en,
    input  logic [W-1:0] clr_idx,
    output logic [N-1:0] bits
);

    logic [N-1:0] bits_q;
    logic [N-1:0] bits_d;

    // Clear applied first so a same-index set overrides it.
    always_comb begin
        bits_d = bits_q;
        if (clr_en) bits_d[clr_idx] = 1'b0;
        if (set_en) bits_d[set_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) bits_q <= '0;
        else     bits_q <= bits_d;
    end

    assign bits = bits_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode interlock for long-latency producers (loads, mul/div): RAW/WAW on pending registers
// and a structural stall on the single mul/div unit. Mul/div tracking is enabled by HAZARD_MULDIV_EN.
module hazard_scoreboard #(
    parameter int unsigned NREGS = hazard_pkg::NREGS,
    parameter int unsigned REG_W = hazard_pkg::REG_W
) (
    input  logic                clk,
    input  logic                rst,
    hazard_scoreboard_if.slave  bus
);
    import hazard_pkg::*;

    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] wb_mask;
    logic [NREGS-1:0] eff;
    logic             raw_rs1;
    logic             raw_rs2;
    logic             raw_hz;
    logic             waw_hz;
    logic             busy_hz;
    logic             is_md;
    logic             md_done;
    logic             md_busy_q;
    logic             issue;
    logic             set_en;
    stall_cause_t     cause;

`ifdef HAZARD_MULDIV_EN
    assign is_md   = bus.id_is_muldiv;
    assign md_done = bus.md_done;
`else
    logic unused_md;
    assign is_md     = 1'b0;
    assign md_done   = 1'b0;
    assign unused_md = bus.id_is_muldiv ^ bus.md_done;
`endif

    // The register being written back this cycle is bypassed by forwarding.
    assign wb_mask = bus.wb_valid ? (NREGS'(1) << bus.wb_rd) : '0;
    assign eff     = pending_q & ~wb_mask;

    assign raw_rs1 = bus.id_rs1_used && (bus.id_rs1 != '0) && eff[bus.id_rs1];
    assign raw_rs2 = bus.id_rs2_used && (bus.id_rs2 != '0) && eff[bus.id_rs2];
    assign raw_hz  = bus.id_valid && (raw_rs1 || raw_rs2);
    assign waw_hz  = bus.id_valid && bus.id_we && (bus.id_rd != '0) && eff[bus.id_rd];
    assign busy_hz = bus.id_valid && is_md && md_busy_q && !md_done;

    always_comb begin
        cause = NONE;
        if (raw_hz)       cause = RAW;
        else if (waw_hz)  cause = WAW;
        else if (busy_hz) cause = BUSY;
    end

    assign bus.stall       = raw_hz || waw_hz || busy_hz;
    assign bus.stall_cause = cause;

    assign issue  = bus.id_valid && !bus.stall && !bus.flush;
    assign set_en = issue && bus.id_we && (bus.id_rd != '0) && (bus.id_is_load || is_md);

    pending_bitmap #(
        .N (NREGS),
        .W (REG_W)
    ) u_pending (
        .clk     (clk),
        .rst     (rst),
        .set_en  (set_en),
        .set_idx (bus.id_rd),
        .clr_en  (bus.wb_valid),
        .clr_idx (bus.wb_rd),
        .bits    (pending_q)
    );

`ifdef HAZARD_MULDIV_EN
    // Issue beats completion so back-to-back mul/div keeps the unit marked busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 md_busy_q <= 1'b0;
        else if (issue && is_md) md_busy_q <= 1'b1;
        else if (md_done)        md_busy_q <= 1'b0;
    end
`else
    assign md_busy_q = 1'b0;
`endif

    assign bus.pending = pending_q;
    assign bus.md_busy = md_busy_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; mul/div steps follow HAZARD_MULDIV_EN.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    hazard_scoreboard_if bus ();

    hazard_scoreboard dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.id_valid     = 1'b0;
        bus.id_rs1       = '0;
        bus.id_rs2       = '0;
        bus.id_rs1_used  = 1'b0;
        bus.id_rs2_used  = 1'b0;
        bus.id_rd        = '0;
        bus.id_we        = 1'b0;
        bus.id_is_load   = 1'b0;
        bus.id_is_muldiv = 1'b0;
        bus.flush        = 1'b0;
        bus.wb_valid     = 1'b0;
        bus.wb_rd        = '0;
        bus.md_done      = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [4:0] rd);
        idle();
        bus.id_valid   = 1'b1;
        bus.id_we      = 1'b1;
        bus.id_rd      = rd;
        bus.id_is_load = 1'b1;
    endtask

    task automatic reader(input logic [4:0] rs1, input logic [4:0] rs2);
        idle();
        bus.id_valid    = 1'b1;
        bus.id_rs1      = rs1;
        bus.id_rs1_used = 1'b1;
        bus.id_rs2      = rs2;
        bus.id_rs2_used = 1'b1;
    endtask

    task automatic muldiv(input logic [4:0] rd);
        idle();
        bus.id_valid     = 1'b1;
        bus.id_we        = 1'b1;
        bus.id_rd        = rd;
        bus.id_is_muldiv = 1'b1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pending", bus.pending, 32'h0);
        check("rst_md_busy", 32'(bus.md_busy), 32'h0);
        check("rst_stall", 32'(bus.stall), 32'h0);
        check("rst_cause", 32'(bus.stall_cause), 32'(NONE));
        rst = 1'b0;
        tick();

        // Load x5, dependent reader stalls until the wb cycle.
        load(5'd5);
        #1 check("ld5_nostall", 32'(bus.stall), 32'h0);
        tick();
        bus.id_is_load = 1'b0;
        bus.id_we      = 1'b0;
        bus.id_rs1     = 5'd5;
        bus.id_rs1_used = 1'b1;
        #1;
        check("ld5_pending", bus.pending, 32'h0000_0020);
        check("raw5_stall", 32'(bus.stall), 32'h1);
        check("raw5_cause", 32'(bus.stall_cause), 32'(RAW));
        bus.flush = 1'b1;
        #1 check("raw5_flush_stall", 32'(bus.stall), 32'h1);
        bus.flush = 1'b0;
        tick();
        check("raw5_hold", 32'(bus.stall), 32'h1);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd5;
        #1;
        check("wb5_bypass_stall", 32'(bus.stall), 32'h0);
        check("wb5_bypass_cause", 32'(bus.stall_cause), 32'(NONE));
        check("wb5_pending_still", bus.pending, 32'h0000_0020);
        tick();
        idle();
        #1 check("wb5_cleared", bus.pending, 32'h0);

        // WAW on x7, RAW outranks WAW.
        load(5'd7);
        tick();
        idle();
        bus.id_valid = 1'b1;
        bus.id_we    = 1'b1;
        bus.id_rd    = 5'd7;
        #1;
        check("waw7_stall", 32'(bus.stall), 32'h1);
        check("waw7_cause", 32'(bus.stall_cause), 32'(WAW));
        bus.id_rs1      = 5'd7;
        bus.id_rs1_used = 1'b1;
        #1 check("raw_over_waw", 32'(bus.stall_cause), 32'(RAW));
        bus.id_rs1_used = 1'b0;
        bus.wb_valid    = 1'b1;
        bus.wb_rd       = 5'd7;
        #1 check("waw7_release", 32'(bus.stall), 32'h0);
        tick();
        idle();
        #1 check("waw7_no_set", bus.pending, 32'h0);

        // Flushed load does not issue.
        load(5'd6);
        bus.flush = 1'b1;
        tick();
        idle();
        #1 check("flush_no_set", bus.pending, 32'h0);

        // Load to x0 never tracked.
        load(5'd0);
        tick();
        reader(5'd0, 5'd0);
        #1;
        check("x0_pending", bus.pending, 32'h0);
        check("x0_stall", 32'(bus.stall), 32'h0);

        // Same-cycle clear and set on x9: set wins.
        load(5'd9);
        tick();
        reader(5'd1, 5'd9);
        #1;
        check("rs2_raw9", 32'(bus.stall_cause), 32'(RAW));
        load(5'd9);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd9;
        #1 check("ld9_reissue_nostall", 32'(bus.stall), 32'h0);
        tick();
        idle();
        #1 check("set_wins9", bus.pending, 32'h0000_0200);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd9;
        tick();
        idle();
        #1 check("clr9", bus.pending, 32'h0);

`ifdef HAZARD_MULDIV_EN
        muldiv(5'd3);
        tick();
        check("md_busy_set", 32'(bus.md_busy), 32'h1);
        check("md_pending3", bus.pending, 32'h0000_0008);
        muldiv(5'd8);
        #1 check("md_busy_cause", 32'(bus.stall_cause), 32'(BUSY));
        bus.id_rs1      = 5'd3;
        bus.id_rs1_used = 1'b1;
        #1 check("raw_over_busy", 32'(bus.stall_cause), 32'(RAW));
        bus.id_rs1_used = 1'b0;
        bus.md_done     = 1'b1;
        #1 check("md_done_release", 32'(bus.stall), 32'h0);
        tick();
        idle();
        #1;
        check("md_busy_setwins", 32'(bus.md_busy), 32'h1);
        check("md_pending3_8", bus.pending, 32'h0000_0108);
        bus.md_done = 1'b1;
        tick();
        idle();
        check("md_busy_clr", 32'(bus.md_busy), 32'h0);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd3;
        tick();
        bus.wb_rd    = 5'd8;
        tick();
        idle();
        check("md_pending_clr", bus.pending, 32'h0);
`else
        muldiv(5'd3);
        tick();
        check("nomd_busy", 32'(bus.md_busy), 32'h0);
        check("nomd_pending", bus.pending, 32'h0);
        muldiv(5'd8);
        #1;
        check("nomd_stall", 32'(bus.stall), 32'h0);
        check("nomd_cause", 32'(bus.stall_cause), 32'(NONE));
        tick();
        idle();
`endif

        // Reset mid-flight drops tracking immediately.
        load(5'd4);
        tick();
        idle();
        #1 check("ld4_pending", bus.pending, 32'h0000_0010);
        rst = 1'b1;
        #1;
        check("midrst_pending", bus.pending, 32'h0);
        check("midrst_md_busy", 32'(bus.md_busy), 32'h0);
        tick();
        rst = 1'b0;
        reader(5'd4, 5'd4);
        #1 check("post_rst_reader", 32'(bus.stall), 32'h0);
        tick();
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
